// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums a programmed number of signed products in a
// guard-bit accumulator, applies a round-half-up arithmetic right shift,
// saturates to PW bits and offers the result on a valid/ready output.
module booth_product_accumulator #(
    parameter int PW = 32,
    parameter int GW = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] len,
    input  logic [4:0]    shift,
    input  logic          prod_valid,
    input  logic [PW-1:0] prod_in,
    output logic          prod_ready,
    output logic          acc_valid,
    input  logic          acc_ready,
    output logic [PW-1:0] acc_out,
    output logic          sat,
    output logic          busy
);

    localparam int AW = PW + GW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [AW-1:0] r_acc;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_shift;
    logic [PW-1:0] r_acc_out;
    logic          r_sat;
    logic          r_acc_valid;

    logic          w_accept;
    logic [AW-1:0] w_prod_ext;
    logic [AW:0]   w_one;
    logic signed [AW:0] w_ext;
    logic signed [AW:0] w_bias;
    logic signed [AW:0] w_sum;
    logic signed [AW:0] w_r;
    logic [AW-PW+1:0]   w_hi;
    logic          w_ovf;

    assign prod_ready = (r_state == ACC);
    assign busy       = (r_state != IDLE);
    assign acc_valid  = r_acc_valid;
    assign acc_out    = r_acc_out;
    assign sat        = r_sat;

    assign w_accept   = prod_valid && prod_ready;
    assign w_prod_ext = {{GW{prod_in[PW-1]}}, prod_in};

    // Rounding is done one bit wider than the accumulator so the bias add
    // cannot wrap; the result fits PW bits only if its top bits are all sign.
    assign w_one  = {{AW{1'b0}}, 1'b1};
    assign w_ext  = {r_acc[AW-1], r_acc};
    assign w_bias = (r_shift != 5'd0) ? (w_one << (r_shift - 5'd1)) : '0;
    assign w_sum  = w_ext + w_bias;
    assign w_r    = w_sum >>> r_shift;
    assign w_hi   = w_r[AW:PW-1];
    assign w_ovf  = !((&w_hi) || !(|w_hi));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (len != '0) ? ACC : ROUND;
                end
            end
            ACC: begin
                if (w_accept && (r_cnt == {{(CW-1){1'b0}}, 1'b1})) begin
                    w_next = ROUND;
                end
            end
            ROUND: begin
                w_next = HOLD;
            end
            HOLD: begin
                if (acc_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Accumulator, run counter and registered result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_acc_out   <= '0;
            r_sat       <= 1'b0;
            r_acc_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_cnt   <= len;
                        r_shift <= shift;
                    end
                end
                ACC: begin
                    if (w_accept) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ROUND: begin
                    if (w_ovf) begin
                        r_acc_out <= w_r[AW] ? {1'b1, {(PW-1){1'b0}}}
                                             : {1'b0, {(PW-1){1'b1}}};
                    end else begin
                        r_acc_out <= w_r[PW-1:0];
                    end
                    r_sat       <= w_ovf;
                    r_acc_valid <= 1'b1;
                end
                HOLD: begin
                    if (acc_ready) begin
                        r_acc_valid <= 1'b0;
                        r_sat       <= 1'b0;
                    end
                end
                default: begin
                    r_acc_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
